// File: rtl/sort_pe.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | sort_pe : odd-even transposition sorter processing element with a     |
// |           neighbour exchange port and a 4-stage compare-and-swap.      |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module sort_pe #(
  parameter int FIX_POINT_WIDTH = 16,
  parameter bit SIGNED          = 1'b1,
  parameter bit ASCENDING       = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load_en,
  input  logic [FIX_POINT_WIDTH-1:0] load_data,
  input  logic                       send_l,
  input  logic                       send_r,
  input  logic                       recv_l,
  input  logic                       recv_r,
  input  logic                       cmp_en,
  input  logic [FIX_POINT_WIDTH-1:0] left_in,
  input  logic [FIX_POINT_WIDTH-1:0] right_in,
  input  logic                       left_in_valid,
  input  logic                       right_in_valid,
  output logic [FIX_POINT_WIDTH-1:0] left_out,
  output logic [FIX_POINT_WIDTH-1:0] right_out,
  output logic                       left_out_valid,
  output logic                       right_out_valid,
  output logic [FIX_POINT_WIDTH-1:0] data_out,
  output logic                       cmp_done,
  output logic                       swap_flag,
  output logic [15:0]                swap_cnt,
  output logic                       proto_err
);

  typedef enum logic [2:0] {
    C_IDLE = 3'd0,
    C_CAP  = 3'd1,
    C_SUB  = 3'd2,
    C_WB   = 3'd3,
    C_WAIT = 3'd4
  } cstate_e;

  cstate_e                    state_q, state_d;
  logic [FIX_POINT_WIDTH-1:0] val_q, val_d, nbr_q, nbr_d;
  logic [FIX_POINT_WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic [FIX_POINT_WIDTH:0]   diff_q, diff_d;
  logic                       nbr_valid_q, nbr_valid_d;
  logic                       cmp_done_q, cmp_done_d;
  logic                       swap_flag_q, swap_flag_d;
  logic [15:0]                swap_cnt_q, swap_cnt_d;
  logic                       proto_err_q, proto_err_d;

  logic [FIX_POINT_WIDTH:0]   w_ext_a, w_ext_b;
  logic                       w_swap, w_recv_err;

  // One extra bit makes the subtraction exact for both signed and unsigned operands.
  assign w_ext_a    = SIGNED ? {op_a_q[FIX_POINT_WIDTH-1], op_a_q} : {1'b0, op_a_q};
  assign w_ext_b    = SIGNED ? {op_b_q[FIX_POINT_WIDTH-1], op_b_q} : {1'b0, op_b_q};
  assign w_swap     = nbr_valid_q &
                      (ASCENDING ? (~diff_q[FIX_POINT_WIDTH] & (|diff_q)) : diff_q[FIX_POINT_WIDTH]);
  assign w_recv_err = (recv_l & ~left_in_valid) | (recv_r & ~right_in_valid);

  always_comb begin
    state_d     = state_q;
    val_d       = val_q;
    nbr_d       = nbr_q;
    nbr_valid_d = nbr_valid_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    diff_d      = diff_q;
    cmp_done_d  = 1'b0;
    swap_flag_d = swap_flag_q;
    swap_cnt_d  = swap_cnt_q;
    proto_err_d = proto_err_q;

    case (state_q)
      C_IDLE: if (cmp_en) state_d = C_CAP;
      C_CAP: begin
        if (cmp_en) begin
          op_a_d  = val_q;
          op_b_d  = nbr_q;
          state_d = C_SUB;
        end else begin
          state_d = C_IDLE;
        end
      end
      C_SUB: begin
        if (cmp_en) begin
          diff_d  = w_ext_a - w_ext_b;
          state_d = C_WB;
        end else begin
          state_d = C_IDLE;
        end
      end
      C_WB: begin
        state_d    = C_WAIT;
        cmp_done_d = 1'b1;
        // A neighbour transfer landing on the writeback edge invalidates the compare.
        if (recv_l | recv_r) begin
          proto_err_d = 1'b1;
        end else begin
          swap_flag_d = w_swap;
          if (w_swap) begin
            val_d = op_b_q;
            nbr_d = op_a_q;
            if (swap_cnt_q != 16'hFFFF) swap_cnt_d = swap_cnt_q + 16'd1;
          end
        end
      end
      C_WAIT: if (!cmp_en) state_d = C_IDLE;
      default: state_d = C_IDLE;
    endcase

    if (send_r) nbr_valid_d = 1'b0;
    if (recv_l) val_d = left_in;
    if (recv_r) begin
      nbr_d       = right_in;
      nbr_valid_d = 1'b1;
    end
    if (w_recv_err) proto_err_d = 1'b1;

    if (load_en) begin
      val_d       = load_data;
      nbr_valid_d = 1'b0;
      swap_cnt_d  = 16'd0;
      swap_flag_d = 1'b0;
      cmp_done_d  = 1'b0;
      state_d     = C_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= C_IDLE;
      val_q       <= '0;
      nbr_q       <= '0;
      nbr_valid_q <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      diff_q      <= '0;
      cmp_done_q  <= 1'b0;
      swap_flag_q <= 1'b0;
      swap_cnt_q  <= 16'd0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      val_q       <= val_d;
      nbr_q       <= nbr_d;
      nbr_valid_q <= nbr_valid_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      diff_q      <= diff_d;
      cmp_done_q  <= cmp_done_d;
      swap_flag_q <= swap_flag_d;
      swap_cnt_q  <= swap_cnt_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign left_out        = val_q;
  assign right_out       = nbr_q;
  assign left_out_valid  = send_l;
  assign right_out_valid = send_r;
  assign data_out        = val_q;
  assign cmp_done        = cmp_done_q;
  assign swap_flag       = swap_flag_q;
  assign swap_cnt        = swap_cnt_q;
  assign proto_err       = proto_err_q;

endmodule
`default_nettype wire

// File: tb/tb_sort_pe.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_sort_pe : three PE variants on shared stimulus plus a two-PE chain. |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_sort_pe;
  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         load_en, send_l, send_r, recv_l, recv_r, cmp_en;
  logic         left_in_valid, right_in_valid;
  logic [W-1:0] load_data, left_in, right_in;

  logic [W-1:0] lo[3], ro[3], dout[3];
  logic         lov[3], rov[3], done[3], sflag[3], perr[3];
  logic [15:0]  scnt[3];

  // Variant 0: signed ascending, 1: unsigned ascending, 2: signed descending.
  for (genvar g = 0; g < 3; g++) begin : g_pe
    sort_pe #(.FIX_POINT_WIDTH(W), .SIGNED(g != 1), .ASCENDING(g != 2)) u_pe (
      .clk(clk), .rst(rst), .load_en(load_en), .load_data(load_data),
      .send_l(send_l), .send_r(send_r), .recv_l(recv_l), .recv_r(recv_r),
      .cmp_en(cmp_en), .left_in(left_in), .right_in(right_in),
      .left_in_valid(left_in_valid), .right_in_valid(right_in_valid),
      .left_out(lo[g]), .right_out(ro[g]), .left_out_valid(lov[g]),
      .right_out_valid(rov[g]), .data_out(dout[g]), .cmp_done(done[g]),
      .swap_flag(sflag[g]), .swap_cnt(scnt[g]), .proto_err(perr[g]));
  end

  // Two-PE chain: PE0's right port faces PE1's left port.
  logic         c_load, c_sl1, c_rr0, c_sr0, c_rl1, c_cmp, c_zero;
  logic [W-1:0] c_d0, c_d1, c_zdata;
  logic [W-1:0] c0_lo, c0_ro, c0_do, c1_lo, c1_ro, c1_do;
  logic         c0_lov, c0_rov, c0_done, c0_sf, c0_pe, c1_lov, c1_rov, c1_done, c1_sf, c1_pe;
  logic [15:0]  c0_cnt, c1_cnt;

  sort_pe u_c0 (
    .clk(clk), .rst(rst), .load_en(c_load), .load_data(c_d0),
    .send_l(c_zero), .send_r(c_sr0), .recv_l(c_zero), .recv_r(c_rr0),
    .cmp_en(c_cmp), .left_in(c_zdata), .right_in(c1_lo),
    .left_in_valid(c_zero), .right_in_valid(c1_lov),
    .left_out(c0_lo), .right_out(c0_ro), .left_out_valid(c0_lov),
    .right_out_valid(c0_rov), .data_out(c0_do), .cmp_done(c0_done),
    .swap_flag(c0_sf), .swap_cnt(c0_cnt), .proto_err(c0_pe));

  sort_pe u_c1 (
    .clk(clk), .rst(rst), .load_en(c_load), .load_data(c_d1),
    .send_l(c_sl1), .send_r(c_zero), .recv_l(c_rl1), .recv_r(c_zero),
    .cmp_en(c_cmp), .left_in(c0_ro), .right_in(c_zdata),
    .left_in_valid(c0_rov), .right_in_valid(c_zero),
    .left_out(c1_lo), .right_out(c1_ro), .left_out_valid(c1_lov),
    .right_out_valid(c1_rov), .data_out(c1_do), .cmp_done(c1_done),
    .swap_flag(c1_sf), .swap_cnt(c1_cnt), .proto_err(c1_pe));

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: the PE as a value/neighbour pair with a compare outcome rule.
  logic [W-1:0] m_val[3], m_nbr[3];
  bit           m_nv[3], m_sf[3], m_pe[3];
  int           m_cnt[3];

  function automatic bit m_should_swap(int g, logic [W-1:0] a, logic [W-1:0] b);
    int ia, ib;
    if (g != 1) begin
      ia = $signed(a);
      ib = $signed(b);
    end else begin
      ia = int'(a);
      ib = int'(b);
    end
    return (g != 2) ? (ia > ib) : (ia < ib);
  endfunction

  task automatic m_reset();
    for (int g = 0; g < 3; g++) begin
      m_val[g] = '0; m_nbr[g] = '0; m_nv[g] = 0; m_sf[g] = 0; m_pe[g] = 0; m_cnt[g] = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("%s/val%0d", tag, g), 32'(dout[g]), 32'(m_val[g]));
      chk($sformatf("%s/lo%0d", tag, g), 32'(lo[g]), 32'(m_val[g]));
      chk($sformatf("%s/nbr%0d", tag, g), 32'(ro[g]), 32'(m_nbr[g]));
      chk($sformatf("%s/sflag%0d", tag, g), 32'(sflag[g]), 32'(m_sf[g]));
      chk($sformatf("%s/scnt%0d", tag, g), 32'(scnt[g]), 32'(m_cnt[g]));
      chk($sformatf("%s/perr%0d", tag, g), 32'(perr[g]), 32'(m_pe[g]));
    end
  endtask

  task automatic do_load(input logic [W-1:0] v);
    load_data = v; load_en = 1'b1;
    tick();
    load_en = 1'b0;
    for (int g = 0; g < 3; g++) begin
      m_val[g] = v; m_nv[g] = 0; m_cnt[g] = 0; m_sf[g] = 0;
    end
  endtask

  task automatic do_recv_r(input logic [W-1:0] v, input bit valid);
    right_in = v; right_in_valid = valid; recv_r = 1'b1;
    tick();
    recv_r = 1'b0; right_in_valid = 1'b0;
    for (int g = 0; g < 3; g++) begin
      m_nbr[g] = v; m_nv[g] = 1;
      if (!valid) m_pe[g] = 1;
    end
  endtask

  task automatic do_recv_l(input logic [W-1:0] v, input bit valid);
    left_in = v; left_in_valid = valid; recv_l = 1'b1;
    tick();
    recv_l = 1'b0; left_in_valid = 1'b0;
    for (int g = 0; g < 3; g++) begin
      m_val[g] = v;
      if (!valid) m_pe[g] = 1;
    end
  endtask

  task automatic do_send(input bit right);
    if (right) send_r = 1'b1; else send_l = 1'b1;
    #1;
    chk(right ? "rov" : "lov", 32'(right ? rov[0] : lov[0]), 32'd1);
    tick();
    send_r = 1'b0; send_l = 1'b0;
    if (right) for (int g = 0; g < 3; g++) m_nv[g] = 0;
  endtask

  // Hold cmp_en for 'hold' edges and watch the done pulse on every variant.
  task automatic do_cmp(input int hold);
    int pulses[3];
    int first;
    bit s;
    pulses = '{0, 0, 0};
    first = 0;
    cmp_en = 1'b1;
    for (int k = 1; k <= hold + 3; k++) begin
      if (k > hold) cmp_en = 1'b0;
      tick();
      for (int g = 0; g < 3; g++) if (done[g]) pulses[g]++;
      if (done[0] && first == 0) first = k;
    end
    for (int g = 0; g < 3; g++)
      chk($sformatf("done_cnt%0d_h%0d", g, hold), 32'(pulses[g]), (hold >= 3) ? 32'd1 : 32'd0);
    if (hold >= 3) begin
      chk("done_latency", 32'(first), 32'd4);
      for (int g = 0; g < 3; g++) begin
        s = m_nv[g] && m_should_swap(g, m_val[g], m_nbr[g]);
        m_sf[g] = s;
        if (s) begin
          logic [W-1:0] t;
          t = m_val[g]; m_val[g] = m_nbr[g]; m_nbr[g] = t;
          if (m_cnt[g] < 16'hFFFF) m_cnt[g]++;
        end
      end
    end
  endtask

  function automatic logic [W-1:0] rand_val();
    case ($urandom_range(0, 3))
      0: return W'($urandom_range(0, 10));
      1: case ($urandom_range(0, 3))
           0: return 16'hFFFF;
           1: return 16'h8000;
           2: return 16'h7FFF;
           default: return 16'h0000;
         endcase
      default: return W'($urandom());
    endcase
  endfunction

  task automatic chain_sort(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] lo_v, hi_v;
    c_d0 = a; c_d1 = b; c_load = 1'b1;
    tick();
    c_load = 1'b0;
    for (int r = 0; r < 4; r++) begin
      c_sl1 = 1'b1; c_rr0 = 1'b1;
      tick();
      c_sl1 = 1'b0; c_rr0 = 1'b0;
      c_cmp = 1'b1;
      repeat (7) tick();
      c_cmp = 1'b0;
      tick();
      c_sr0 = 1'b1; c_rl1 = 1'b1;
      tick();
      c_sr0 = 1'b0; c_rl1 = 1'b0;
    end
    if ($signed(a) < $signed(b)) begin lo_v = a; hi_v = b; end
    else begin lo_v = b; hi_v = a; end
    chk("chain_pe0", 32'(c0_do), 32'(lo_v));
    chk("chain_pe1", 32'(c1_do), 32'(hi_v));
    chk("chain_perr0", 32'(c0_pe), 32'd0);
    chk("chain_perr1", 32'(c1_pe), 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    load_en = 0; send_l = 0; send_r = 0; recv_l = 0; recv_r = 0; cmp_en = 0;
    left_in_valid = 0; right_in_valid = 0; load_data = '0; left_in = '0; right_in = '0;
    c_load = 0; c_sl1 = 0; c_rr0 = 0; c_sr0 = 0; c_rl1 = 0; c_cmp = 0; c_zero = 0;
    c_d0 = '0; c_d1 = '0; c_zdata = '0;
    m_reset();
    tick(); tick();
    check_all("reset");
    chk("reset_done", 32'(done[0]), 32'd0);
    rst = 1'b1;
    tick();

    do_load(16'd5); do_recv_r(16'd3, 1'b1); do_cmp(7);
    check_all("asc_swap");
    chk("asc_val", 32'(dout[0]), 32'd3);
    chk("asc_cnt", 32'(scnt[0]), 32'd1);

    do_load(16'hFFFF); do_recv_r(16'd1, 1'b1); do_cmp(7);
    check_all("sign");
    chk("signed_keep", 32'(dout[0]), 32'hFFFF);
    chk("unsigned_swap", 32'(dout[1]), 32'd1);

    do_load(16'd7); do_recv_r(16'd7, 1'b1); do_cmp(5);
    check_all("equal");

    do_load(16'd9); do_cmp(3);
    check_all("chain_end");

    do_load(16'd40); do_recv_r(16'd2, 1'b1); do_cmp(2);
    check_all("abort");
    do_cmp(1);
    check_all("abort1");

    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 7))
        0: do_load(rand_val());
        1, 2: do_recv_r(rand_val(), $urandom_range(0, 9) != 0);
        3: do_recv_l(rand_val(), $urandom_range(0, 9) != 0);
        4: do_send($urandom_range(0, 1) != 0);
        default: do_cmp($urandom_range(1, 7));
      endcase
      check_all($sformatf("rnd%0d", i));
    end

    do_load(16'd20); do_recv_r(16'd10, 1'b1);
    cmp_en = 1'b1;
    repeat (3) tick();
    left_in = 16'h0042; left_in_valid = 1'b1; recv_l = 1'b1;
    tick();
    recv_l = 1'b0; left_in_valid = 1'b0; cmp_en = 1'b0;
    tick(); tick();
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("coll_val%0d", g), 32'(dout[g]), 32'h42);
      chk($sformatf("coll_perr%0d", g), 32'(perr[g]), 32'd1);
    end

    do_load(16'd9); do_recv_r(16'd1, 1'b1);
    cmp_en = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    m_reset();
    check_all("async_rst");
    chk("async_rst_done", 32'(done[0]), 32'd0);
    cmp_en = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    do_cmp(7);
    check_all("post_rst");

    chain_sort(16'd9, 16'd2);
    chain_sort(rand_val(), rand_val());
    chain_sort(W'($urandom()), W'($urandom()));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
